muldiv_issue_arbiter: RTL

- Shares the single multiply/divide functional unit between NR_REQ issue requesters.
- Round-robin grant with divider-occupancy gating and per-transaction ownership tracking, so each result is routed back to the requester that issued it.
- Sits between the issue ports and the mult unit; drives the unit's valid and operand-select, and consumes its ready, valid and trans-id outputs.

---
 rtl/muldiv_issue_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_issue_arbiter.sv
// rtl/muldiv_issue_arbiter.sv - round-robin issue arbiter and result router for the shared mult/div unit
//
// Purpose: picks at most one of NR_REQ issue requesters per cycle for the shared
// multiply/divide unit, gates divides on divider occupancy, records which
// requester owns each transaction id and routes each result back to it.
//
// Ports:
//   clk_i, rst_ni           clock, synchronous active-low reset
//   flush_i                 pipeline flush: no grant, drops all in-flight ownership
//   req_valid_i/is_div_i    per-requester request and operation family
//   req_trans_id_i          packed per-requester trans ids
//   req_ready_o             one-hot accept to the winning requester
//   fu_valid_o/sel_o/trans_id_o  issue to the unit (operand mux select = winner)
//   fu_ready_i              divider can take a new op (multiplies ignore it)
//   res_valid_i/trans_id_i  result from the unit
//   resp_valid_o            one-hot return strobe to the owning requester
//   resp_trans_id_o         passthrough of res_trans_id_i
//   busy_o                  any transaction in flight
//   spurious_o              result for a trans id that is not in flight
//   div_stall_cnt_o, tid_stall_cnt_o  stall counters, only with MULDIV_ARB_PERF_EN
//
// Optional build macro: MULDIV_ARB_PERF_EN adds the saturating stall counters.

module muldiv_issue_arbiter #(
    parameter int NR_REQ        = 2,
    parameter int TRANS_ID_BITS = 3,
    parameter int SEL_W         = $clog2(NR_REQ)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              flush_i,
    input  logic [NR_REQ-1:0]                 req_valid_i,
    input  logic [NR_REQ-1:0]                 req_is_div_i,
    input  logic [NR_REQ*TRANS_ID_BITS-1:0]   req_trans_id_i,
    output logic [NR_REQ-1:0]                 req_ready_o,
    output logic                              fu_valid_o,
    output logic [SEL_W-1:0]                  fu_sel_o,
    output logic [TRANS_ID_BITS-1:0]          fu_trans_id_o,
    input  logic                              fu_ready_i,
    input  logic                              res_valid_i,
    input  logic [TRANS_ID_BITS-1:0]          res_trans_id_i,
    output logic [NR_REQ-1:0]                 resp_valid_o,
    output logic [TRANS_ID_BITS-1:0]          resp_trans_id_o,
    output logic                              busy_o,
    output logic                              spurious_o
`ifdef MULDIV_ARB_PERF_EN
    ,
    output logic [31:0]                       div_stall_cnt_o,
    output logic [31:0]                       tid_stall_cnt_o
`endif
);

    localparam int NR_TID = 2 ** TRANS_ID_BITS;

    logic [SEL_W-1:0]         rr_q;
    logic [NR_TID-1:0]        inflight_q;
    logic [SEL_W-1:0]         owner_q [NR_TID];
    logic                     div_busy_q;
    logic [TRANS_ID_BITS-1:0] div_tid_q;

    logic [TRANS_ID_BITS-1:0] req_tid [NR_REQ];
    logic [NR_REQ-1:0]        tid_free;
    logic [NR_REQ-1:0]        div_ok;
    logic [NR_REQ-1:0]        eligible;
    logic                     grant;
    logic [SEL_W-1:0]         win;
    logic [SEL_W-1:0]         rr_nxt;
    logic                     res_hit;

    for (genvar r = 0; r < NR_REQ; r++) begin : g_tid
        assign req_tid[r] = req_trans_id_i[r*TRANS_ID_BITS +: TRANS_ID_BITS];
    end

    // Eligibility uses the pre-retire inflight_q, so a tid retiring this cycle
    // can only be re-issued next cycle. Since only the first eligible index is
    // granted, a later index can never take the same tid in the same cycle.
    always_comb begin
        tid_free = '0;
        div_ok   = '0;
        eligible = '0;
        for (int r = 0; r < NR_REQ; r++) begin
            tid_free[r] = ~inflight_q[req_tid[r]];
            div_ok[r]   = ~req_is_div_i[r] | (fu_ready_i & ~div_busy_q);
            eligible[r] = req_valid_i[r] & ~flush_i & tid_free[r] & div_ok[r];
        end
    end

    always_comb begin
        grant = 1'b0;
        win   = '0;
        for (int k = 0; k < NR_REQ; k++) begin
            if (!grant && eligible[(int'(rr_q) + k) % NR_REQ]) begin
                grant = 1'b1;
                win   = SEL_W'((int'(rr_q) + k) % NR_REQ);
            end
        end
        rr_nxt = (win == SEL_W'(NR_REQ - 1)) ? '0 : win + 1'b1;
    end

    always_comb begin
        req_ready_o  = '0;
        resp_valid_o = '0;
        res_hit      = res_valid_i & inflight_q[res_trans_id_i];
        for (int r = 0; r < NR_REQ; r++) begin
            req_ready_o[r]  = grant & (win == SEL_W'(r));
            resp_valid_o[r] = res_hit & (owner_q[res_trans_id_i] == SEL_W'(r));
        end
    end

    assign fu_valid_o      = grant;
    assign fu_sel_o        = grant ? win : '0;
    assign fu_trans_id_o   = grant ? req_tid[win] : '0;
    assign resp_trans_id_o = res_trans_id_i;
    assign busy_o          = |inflight_q;
    assign spurious_o      = res_valid_i & ~inflight_q[res_trans_id_i];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            inflight_q <= '0;
            div_busy_q <= 1'b0;
            div_tid_q  <= '0;
            for (int t = 0; t < NR_TID; t++) begin
                owner_q[t] <= '0;
            end
        end else if (flush_i) begin
            inflight_q <= '0;
            div_busy_q <= 1'b0;
        end else begin
            if (res_hit) begin
                inflight_q[res_trans_id_i] <= 1'b0;
                if (div_busy_q && res_trans_id_i == div_tid_q) begin
                    div_busy_q <= 1'b0;
                end
            end
            // A granted tid was not in flight, so it never collides with the
            // retire above; a div grant needs ~div_busy_q, so it never
            // collides with the divider release either.
            if (grant) begin
                rr_q                        <= rr_nxt;
                inflight_q[fu_trans_id_o]   <= 1'b1;
                owner_q[fu_trans_id_o]      <= win;
                if (req_is_div_i[win]) begin
                    div_busy_q <= 1'b1;
                    div_tid_q  <= fu_trans_id_o;
                end
            end
        end
    end

`ifdef MULDIV_ARB_PERF_EN
    logic div_stall;
    logic tid_stall;

    always_comb begin
        div_stall = 1'b0;
        tid_stall = 1'b0;
        for (int r = 0; r < NR_REQ; r++) begin
            if (req_valid_i[r] && !flush_i) begin
                if (req_is_div_i[r] && tid_free[r] && !div_ok[r]) div_stall = 1'b1;
                if (!tid_free[r] && div_ok[r])                      tid_stall = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            div_stall_cnt_o <= '0;
            tid_stall_cnt_o <= '0;
        end else begin
            if (div_stall && div_stall_cnt_o != '1) div_stall_cnt_o <= div_stall_cnt_o + 32'd1;
            if (tid_stall && tid_stall_cnt_o != '1) tid_stall_cnt_o <= tid_stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule
